// File: rtl/p_id_operand_stage.sv
// p_id_operand_stage
//   Decode-stage operand resolution and ID/EX output latch.
//   Each source operand comes from one of: the alternate value (immediate/PC),
//   hardwired zero for x0, the youngest matching forwarding port, or the
//   register file. A loading forward match on a needed operand is a load-use
//   hazard: the stage refuses the instruction and counts the stall cycle.
//
// Ports
//   clk_in, rst_n_in            clock, async active-low reset
//   rdy_in                      global pause (0 freezes every register)
//   flush_in                    empties the output latch
//   in_*                        decoded instruction, valid/ready handshake
//   rf_raddr*/rf_rdata*         register-file read port (same-cycle data)
//   fwd_*                       NFWD forwarding ports, slice 0 = youngest
//   out_*                       ID/EX latch, valid/ready handshake
//   hazard, stall_cnt           load-use stall flag and saturating counter
module p_id_operand_stage #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NFWD  = 2,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 in_re1,
  input  logic                 in_re2,
  input  logic [AW-1:0]        in_addr1,
  input  logic [AW-1:0]        in_addr2,
  input  logic [XLEN-1:0]      in_alt1,
  input  logic [XLEN-1:0]      in_alt2,
  input  logic                 in_we,
  input  logic [AW-1:0]        in_waddr,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_loading,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [TAG_W-1:0]     out_tag,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic                 out_we,
  output logic [AW-1:0]        out_waddr,
  output logic                 hazard,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic [XLEN-1:0] op1, op2;
  logic            pend1, pend2;
  logic            xfer;

  // Returns {pending, value}. Ports are scanned oldest to youngest so the
  // youngest match overwrites; x0 and alternate selection override last.
  function automatic logic [XLEN:0] resolve(
    input logic                 re,
    input logic [AW-1:0]        addr,
    input logic [XLEN-1:0]      alt,
    input logic [XLEN-1:0]      rdata,
    input logic [NFWD-1:0]      f_we,
    input logic [NFWD*AW-1:0]   f_waddr,
    input logic [NFWD*XLEN-1:0] f_wdata,
    input logic [NFWD-1:0]      f_loading
  );
    logic [XLEN-1:0] val;
    logic            pend;
    val  = rdata;
    pend = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if ((f_we[k] || f_loading[k]) && (f_waddr[k*AW +: AW] == addr)) begin
        val  = f_wdata[k*XLEN +: XLEN];
        pend = f_loading[k];
      end
    end
    if (addr == '0) begin
      val  = '0;
      pend = 1'b0;
    end
    if (!re) begin
      val  = alt;
      pend = 1'b0;
    end
    return {pend, val};
  endfunction

  assign rf_raddr1 = in_addr1;
  assign rf_raddr2 = in_addr2;

  always_comb begin
    {pend1, op1} = resolve(in_re1, in_addr1, in_alt1, rf_rdata1,
                           fwd_we, fwd_waddr, fwd_wdata, fwd_loading);
    {pend2, op2} = resolve(in_re2, in_addr2, in_alt2, rf_rdata2,
                           fwd_we, fwd_waddr, fwd_wdata, fwd_loading);
  end

  assign hazard   = in_valid && (pend1 || pend2);
  assign in_ready = rdy_in && !flush_in && !hazard && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_tag   <= '0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_we    <= 1'b0;
      out_waddr <= '0;
      stall_cnt <= '0;
    end else if (rdy_in) begin
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_in) begin
        out_valid <= 1'b0;
      end else if (xfer) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_tag   <= in_tag;
        out_op1   <= op1;
        out_op2   <= op2;
        out_we    <= in_we;
        out_waddr <= in_waddr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_p_id_operand_stage.sv
module tb_p_id_operand_stage;
  localparam int XLEN = 32, AW = 5, NFWD = 2, TAG_W = 8;

  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, flush_in, in_valid, in_re1, in_re2, in_we, out_ready;
  logic [XLEN-1:0] in_pc, in_alt1, in_alt2, rf_rdata1, rf_rdata2;
  logic [TAG_W-1:0] in_tag;
  logic [AW-1:0] in_addr1, in_addr2, in_waddr;
  logic [NFWD-1:0] fwd_we, fwd_loading;
  logic [NFWD*AW-1:0] fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;

  logic in_ready, out_valid, out_we, hazard;
  logic [AW-1:0] rf_raddr1, rf_raddr2, out_waddr;
  logic [XLEN-1:0] out_pc, out_op1, out_op2;
  logic [TAG_W-1:0] out_tag;
  logic [15:0] stall_cnt;

  logic s_in_ready, s_out_valid, s_out_we, s_hazard;
  logic [AW-1:0] s_rf_raddr1, s_rf_raddr2, s_out_waddr;
  logic [XLEN-1:0] s_out_pc, s_out_op1, s_out_op2;
  logic [TAG_W-1:0] s_out_tag;
  logic [1:0] s_stall_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  p_id_operand_stage dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_tag(in_tag),
    .in_re1(in_re1), .in_re2(in_re2), .in_addr1(in_addr1), .in_addr2(in_addr2),
    .in_alt1(in_alt1), .in_alt2(in_alt2), .in_we(in_we), .in_waddr(in_waddr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_loading(fwd_loading),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_tag(out_tag),
    .out_op1(out_op1), .out_op2(out_op2), .out_we(out_we), .out_waddr(out_waddr),
    .hazard(hazard), .stall_cnt(stall_cnt)
  );

  p_id_operand_stage #(.CNT_W(2)) dut_sat (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_tag(in_tag),
    .in_re1(in_re1), .in_re2(in_re2), .in_addr1(in_addr1), .in_addr2(in_addr2),
    .in_alt1(in_alt1), .in_alt2(in_alt2), .in_we(in_we), .in_waddr(in_waddr),
    .rf_raddr1(s_rf_raddr1), .rf_raddr2(s_rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_loading(fwd_loading),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_tag(s_out_tag),
    .out_op1(s_out_op1), .out_op2(s_out_op2), .out_we(s_out_we), .out_waddr(s_out_waddr),
    .hazard(s_hazard), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_tag = '0; in_re1 = 1'b0; in_re2 = 1'b0;
    in_addr1 = '0; in_addr2 = '0; in_alt1 = '0; in_alt2 = '0;
    in_we = 1'b0; in_waddr = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_loading = '0;
  endtask

  initial begin
    rst_n_in = 1'b0;
    idle_inputs();
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    rst_n_in = 1'b1;

    // ADD x3,x1,x2 from register file
    in_valid = 1'b1; in_pc = 32'h100; in_tag = 8'h12;
    in_re1 = 1'b1; in_re2 = 1'b1; in_addr1 = 5'd1; in_addr2 = 5'd2;
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd7; in_we = 1'b1; in_waddr = 5'd3;
    #1;
    chk("add_ready", 64'(in_ready), 64'd1);
    chk("add_raddr1", 64'(rf_raddr1), 64'd1);
    chk("add_raddr2", 64'(rf_raddr2), 64'd2);
    step();
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_op1", 64'(out_op1), 64'd5);
    chk("add_op2", 64'(out_op2), 64'd7);
    chk("add_waddr", 64'(out_waddr), 64'd3);
    chk("add_pc", 64'(out_pc), 64'h100);
    chk("add_tag", 64'(out_tag), 64'h12);
    chk("add_we", 64'(out_we), 64'd1);

    // bubble: payload holds
    in_valid = 1'b0;
    step();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_op1", 64'(out_op1), 64'd5);

    // forwarding priority: port 0 beats port 1 beats rf
    in_valid = 1'b1; in_pc = 32'h104; rf_rdata1 = 32'h11;
    fwd_we = 2'b11; fwd_waddr = {5'd1, 5'd1}; fwd_wdata = {32'hBB, 32'hAA};
    step();
    chk("fwd_prio_op1", 64'(out_op1), 64'hAA);
    chk("fwd_prio_op2", 64'(out_op2), 64'd7);

    // x0 is never forwarded
    in_addr1 = 5'd0; fwd_waddr = {5'd1, 5'd0};
    step();
    chk("x0_op1", 64'(out_op1), 64'd0);

    // alternate value overrides a forward match
    in_re1 = 1'b0; in_alt1 = 32'h1234; in_addr1 = 5'd1; fwd_waddr = {5'd1, 5'd1};
    step();
    chk("alt_op1", 64'(out_op1), 64'h1234);

    // load-use hazard on x2 from port 1
    in_re1 = 1'b1; in_pc = 32'h180; rf_rdata1 = 32'd5;
    fwd_we = 2'b00; fwd_loading = 2'b10; fwd_waddr = {5'd2, 5'd0}; fwd_wdata = '0;
    #1;
    chk("haz_flag", 64'(hazard), 64'd1);
    chk("haz_ready", 64'(in_ready), 64'd0);
    step();
    chk("haz_valid", 64'(out_valid), 64'd0);
    chk("haz_cnt1", 64'(stall_cnt), 64'd1);
    step();
    chk("haz_cnt2", 64'(stall_cnt), 64'd2);
    step(); step(); step(); step();
    chk("haz_cnt6", 64'(stall_cnt), 64'd6);
    chk("sat_cnt", 64'(s_stall_cnt), 64'd3);

    // younger non-loading match masks older loading match
    fwd_we = 2'b01; fwd_waddr = {5'd2, 5'd2}; fwd_wdata = {32'h0, 32'h55};
    #1;
    chk("mask_haz", 64'(hazard), 64'd0);
    step();
    chk("mask_op2", 64'(out_op2), 64'h55);
    chk("mask_cnt", 64'(stall_cnt), 64'd6);

    // load data arrives on port 1
    fwd_loading = 2'b00; fwd_we = 2'b10; fwd_waddr = {5'd2, 5'd0}; fwd_wdata = {32'h44, 32'h0};
    #1;
    chk("res_haz", 64'(hazard), 64'd0);
    step();
    chk("res_valid", 64'(out_valid), 64'd1);
    chk("res_op2", 64'(out_op2), 64'h44);

    // backpressure: payload stable, upstream blocked
    out_ready = 1'b0; in_pc = 32'h200; fwd_we = 2'b00; rf_rdata2 = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(in_ready), 64'd0);
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_pc", 64'(out_pc), 64'h180);
      chk("bp_op2", 64'(out_op2), 64'h44);
    end
    flush_in = 1'b1;
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pc", 64'(out_pc), 64'h180);
    flush_in = 1'b0; out_ready = 1'b1;

    // global pause blocks transfer and freezes the counter
    rdy_in = 1'b0; in_pc = 32'h300;
    #1;
    chk("pause_ready", 64'(in_ready), 64'd0);
    step();
    chk("pause_valid", 64'(out_valid), 64'd0);
    chk("pause_pc", 64'(out_pc), 64'h180);
    fwd_loading = 2'b10;
    step();
    chk("pause_cnt", 64'(stall_cnt), 64'd6);
    fwd_loading = 2'b00; rdy_in = 1'b1;
    step();
    chk("go_valid", 64'(out_valid), 64'd1);
    chk("go_pc", 64'(out_pc), 64'h300);
    chk("go_op2", 64'(out_op2), 64'h99);
    fwd_loading = 2'b10;
    step();
    chk("stall7_cnt", 64'(stall_cnt), 64'd7);

    // asynchronous reset mid-stall
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_pc", 64'(out_pc), 64'd0);
    chk("arst_op1", 64'(out_op1), 64'd0);
    chk("arst_op2", 64'(out_op2), 64'd0);
    chk("arst_waddr", 64'(out_waddr), 64'd0);
    chk("arst_we", 64'(out_we), 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    chk("arst_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_sat_cnt", 64'(s_stall_cnt), 64'd0);
    rst_n_in = 1'b1;
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
